pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage CPU, replacing the per-stage hand-written E/M-style registers. It carries a generic payload plus the hazard-control fields (PC, Tnew, register-write enable and address) between adjacent stages. It adds a valid/ready handshake, synchronous flush, bubble insertion and saturating Tnew countdown. An optional skid buffer breaks the combinational ready path.

---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_skid_buf.sv | 45 ++++
 rtl/pipe_stage_reg.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers and the hazard unit.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pipe_pkg;

    localparam int PIPE_PC_W   = 32;
    localparam int PIPE_TNEW_W = 2;
    localparam int PIPE_ADDR_W = 5;

    // Widest Tnew field sat_dec_tnew handles; stage instances cast to/from it.
    localparam int TNEW_MAX_W  = 8;

    typedef struct packed {
        logic [PIPE_PC_W-1:0]   pc;
        logic [PIPE_TNEW_W-1:0] tnew;
        logic                   reg_we;
        logic [PIPE_ADDR_W-1:0] reg_wa;
    } pipe_ctrl_t;

    // Tnew counts down once per stage crossed and never wraps below zero.
    function automatic logic [TNEW_MAX_W-1:0] sat_dec_tnew(input logic [TNEW_MAX_W-1:0] t);
        logic [TNEW_MAX_W-1:0] one;
        one = {{(TNEW_MAX_W-1){1'b0}}, 1'b1};
        return (t == '0) ? '0 : (t - one);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid store for pipe_stage_reg; holds an entry that arrived while downstream stalled.
// Latency: push visible on vld_o the cycle after; pop frees the slot the cycle after.
// Backpressure: none internally; the parent only pushes when empty. clr_i wins over push/pop.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] dat_i,
    output logic         vld_o,
    output logic [W-1:0] dat_o
);

    logic         vld_q;
    logic [W-1:0] dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else if (clr_i) begin
            vld_q <= 1'b0;
        end else if (push_i) begin
            vld_q <= 1'b1;
        end else if (pop_i) begin
            vld_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_q <= '0;
        end else if (push_i && !clr_i) begin
            dat_q <= dat_i;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (PC, Tnew, reg write en/addr, payload) with valid/ready, flush, bubbles.
// Latency: 1 cycle in->out; one transfer per cycle when out_ready stays high.
// Backpressure: in_ready = out_ready || !out_valid; with PIPE_REG_SKID_EN, in_ready = skid empty (registered).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int TNEW_W = PIPE_TNEW_W,   // must not exceed TNEW_MAX_W
    parameter int ADDR_W = PIPE_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [TNEW_W-1:0] in_tnew,
    input  logic              in_reg_we,
    input  logic [ADDR_W-1:0] in_reg_wa,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [TNEW_W-1:0] out_tnew,
    output logic              out_reg_we,
    output logic [ADDR_W-1:0] out_reg_wa,
    output logic [DATA_W-1:0] out_data
);

    logic              vld_q,  vld_d;
    logic [31:0]       pc_q,   pc_d;
    logic [TNEW_W-1:0] tnew_q, tnew_d;
    logic              we_q,   we_d;
    logic [ADDR_W-1:0] wa_q,   wa_d;
    logic [DATA_W-1:0] data_q, data_d;

    // Holds in_ready low until the first edge after reset release.
    logic              rdy_en_q;

    logic              in_xfer;
    logic              out_xfer;
    logic [TNEW_W-1:0] in_tnew_dec;

    // Tnew is decremented once as the instruction enters the stage.
    assign in_tnew_dec = TNEW_W'(sat_dec_tnew(TNEW_MAX_W'(in_tnew)));

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = vld_q && out_ready;

`ifdef PIPE_REG_SKID_EN
    localparam int ENTRY_W = 32 + TNEW_W + 1 + ADDR_W + DATA_W;

    logic               skid_vld;
    logic               skid_push;
    logic               skid_pop;
    logic [ENTRY_W-1:0] skid_dat;
    logic [31:0]        skid_pc;
    logic [TNEW_W-1:0]  skid_tnew;
    logic               skid_we;
    logic [ADDR_W-1:0]  skid_wa;
    logic [DATA_W-1:0]  skid_data;

    pipe_skid_buf #(
        .W (ENTRY_W)
    ) u_skid (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (flush),
        .push_i (skid_push),
        .pop_i  (skid_pop),
        .dat_i  ({in_pc, in_tnew_dec, in_reg_we, in_reg_wa, in_data}),
        .vld_o  (skid_vld),
        .dat_o  (skid_dat)
    );

    assign {skid_pc, skid_tnew, skid_we, skid_wa, skid_data} = skid_dat;

    // Registered ready: only flops feed it, so no combinational path from out_ready.
    assign in_ready = rdy_en_q && !skid_vld;
`else
    assign in_ready = rdy_en_q && (out_ready || !vld_q);
`endif

    always_comb begin
        vld_d  = vld_q;
        pc_d   = pc_q;
        tnew_d = tnew_q;
        we_d   = we_q;
        wa_d   = wa_q;
        data_d = data_q;
`ifdef PIPE_REG_SKID_EN
        skid_push = 1'b0;
        skid_pop  = 1'b0;
`endif
        if (flush) begin
            // Any concurrent in/out transfer is dropped; pc/wa/data left as-is.
            vld_d  = 1'b0;
            we_d   = 1'b0;
            tnew_d = '0;
`ifdef PIPE_REG_SKID_EN
        end else if (skid_vld) begin
            // in_ready is low here, so the only event is draining the skid on an out transfer.
            if (out_xfer) begin
                skid_pop = 1'b1;
                pc_d     = skid_pc;
                tnew_d   = skid_tnew;
                we_d     = skid_we;
                wa_d     = skid_wa;
                data_d   = skid_data;
            end
        end else if (in_xfer && vld_q && !out_ready) begin
            skid_push = 1'b1;
`endif
        end else if (in_xfer) begin
            vld_d  = 1'b1;
            pc_d   = in_pc;
            tnew_d = in_tnew_dec;
            we_d   = in_reg_we;
            wa_d   = in_reg_wa;
            data_d = in_data;
        end else if (out_xfer) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q <= 1'b0;
            vld_q    <= 1'b0;
            pc_q     <= '0;
            tnew_q   <= '0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            data_q   <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            vld_q    <= vld_d;
            pc_q     <= pc_d;
            tnew_q   <= tnew_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            data_q   <= data_d;
        end
    end

    // A bubble must never look like a hazard or forwarding source.
    assign out_valid  = vld_q;
    assign out_pc     = pc_q;
    assign out_tnew   = vld_q ? tnew_q : '0;
    assign out_reg_we = we_q && vld_q;
    assign out_reg_wa = wa_q;
    assign out_data   = data_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [1:0]  in_tnew;
    logic        in_reg_we;
    logic [4:0]  in_reg_wa;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [1:0]  out_tnew;
    logic        out_reg_we;
    logic [4:0]  out_reg_wa;
    logic [63:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_tnew    (in_tnew),
        .in_reg_we  (in_reg_we),
        .in_reg_wa  (in_reg_wa),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_tnew   (out_tnew),
        .out_reg_we (out_reg_we),
        .out_reg_wa (out_reg_wa),
        .out_data   (out_data)
    );

    task automatic drive(input logic v, input logic [31:0] pc, input logic [1:0] tn,
                         input logic we, input logic [4:0] wa, input logic [63:0] d);
        in_valid  = v;
        in_pc     = pc;
        in_tnew   = tn;
        in_reg_we = we;
        in_reg_wa = wa;
        in_data   = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 32'h0, 2'd0, 1'b0, 5'd0, 64'h0);
        repeat (3) tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0b exp 0", in_ready); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp 0", out_pc); end
        n_checks++; if (out_tnew !== 2'd0 || out_reg_we !== 1'b0 || out_reg_wa !== 5'd0) begin
            n_fail++; $display("FAIL reset_ctrl got tnew=%0d we=%0b wa=%0d exp 0/0/0", out_tnew, out_reg_we, out_reg_wa); end
        n_checks++; if (out_data !== 64'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", out_data); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got %0b exp 1", in_ready); end
    endtask

    task automatic test_stream();
        drive(1'b1, 32'h3000, 2'd2, 1'b1, 5'd8, 64'hA5A5_0000_0000_0001);
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid got %0b exp 1", out_valid); end
        n_checks++; if (out_tnew !== 2'd1) begin n_fail++; $display("FAIL stream_tnew got %0d exp 1", out_tnew); end
        n_checks++; if (out_reg_wa !== 5'd8 || out_reg_we !== 1'b1) begin
            n_fail++; $display("FAIL stream_wa got wa=%0d we=%0b exp 8/1", out_reg_wa, out_reg_we); end
        n_checks++; if (out_pc !== 32'h3000 || out_data !== 64'hA5A5_0000_0000_0001) begin
            n_fail++; $display("FAIL stream_pc_data got %h/%h exp 3000/a5a5000000000001", out_pc, out_data); end
    endtask

    // Back-to-back pushes also cover tnew saturation and the $0 write pass-through.
    task automatic test_tnew_sat();
        drive(1'b1, 32'h3004, 2'd0, 1'b1, 5'd0, 64'h11);
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3004) begin
            n_fail++; $display("FAIL b2b_1 got v=%0b pc=%h exp 1/3004", out_valid, out_pc); end
        n_checks++; if (out_tnew !== 2'd0) begin n_fail++; $display("FAIL tnew_sat0 got %0d exp 0", out_tnew); end
        n_checks++; if (out_reg_we !== 1'b1 || out_reg_wa !== 5'd0) begin
            n_fail++; $display("FAIL zero_wa got we=%0b wa=%0d exp 1/0", out_reg_we, out_reg_wa); end
        drive(1'b1, 32'h3008, 2'd3, 1'b1, 5'd9, 64'h22);
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3008) begin
            n_fail++; $display("FAIL b2b_2 got v=%0b pc=%h exp 1/3008", out_valid, out_pc); end
        n_checks++; if (out_tnew !== 2'd2) begin n_fail++; $display("FAIL tnew_dec3 got %0d exp 2", out_tnew); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(1'b1, 32'h4000, 2'd2, 1'b1, 5'd10, 64'h33);
        #1;
`ifdef PIPE_REG_SKID_EN
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_skid_accept got %0b exp 1", in_ready); end
        tick();
        drive(1'b1, 32'h5000, 2'd3, 1'b1, 5'd11, 64'h44);
        #1;
`endif
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %0b exp 0", in_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3008 || out_tnew !== 2'd2 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold[%0d] got v=%0b pc=%h tnew=%0d rdy=%0b exp 1/3008/2/0",
                                   i, out_valid, out_pc, out_tnew, in_ready); end
        end
        out_ready = 1'b1;
        tick();
`ifndef PIPE_REG_SKID_EN
        in_valid = 1'b0;
`endif
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h4000 || out_tnew !== 2'd1) begin
            n_fail++; $display("FAIL release_1 got v=%0b pc=%h tnew=%0d exp 1/4000/1", out_valid, out_pc, out_tnew); end
`ifdef PIPE_REG_SKID_EN
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL skid_drained_rdy got %0b exp 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h5000 || out_tnew !== 2'd2) begin
            n_fail++; $display("FAIL release_2 got v=%0b pc=%h tnew=%0d exp 1/5000/2", out_valid, out_pc, out_tnew); end
`endif
    endtask

    task automatic test_bubble();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_reg_we !== 1'b0 || out_tnew !== 2'd0) begin
            n_fail++; $display("FAIL bubble got v=%0b we=%0b tnew=%0d exp 0/0/0", out_valid, out_reg_we, out_tnew); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h6000, 2'd3, 1'b1, 5'd12, 64'h55);
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_tnew !== 2'd2) begin
            n_fail++; $display("FAIL flush_pre got v=%0b tnew=%0d exp 1/2", out_valid, out_tnew); end
        drive(1'b1, 32'h6004, 2'd3, 1'b1, 5'd13, 64'h66);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || out_reg_we !== 1'b0 || out_tnew !== 2'd0) begin
            n_fail++; $display("FAIL flush_collide got v=%0b we=%0b tnew=%0d exp 0/0/0", out_valid, out_reg_we, out_tnew); end
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %0b exp 1", in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard got v=%0b exp 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 32'h7000, 2'd2, 1'b1, 5'd14, 64'h77);
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h7000) begin
            n_fail++; $display("FAIL areset_pre got v=%0b pc=%h exp 1/7000", out_valid, out_pc); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_data !== 64'h0 || out_reg_we !== 1'b0 || out_reg_wa !== 5'd0) begin
            n_fail++; $display("FAIL areset_clear got v=%0b pc=%h data=%h we=%0b wa=%0d exp all 0",
                               out_valid, out_pc, out_data, out_reg_we, out_reg_wa); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL areset_ready got %0b exp 0", in_ready); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_tnew_sat();
        test_stall();
        test_bubble();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
